// File: rtl/dispenser_ctrl_gen2_if.sv
// Bundles the dispenser controller's sensor inputs and its display/actuator
// outputs so the controller and its environment share one connection.
//   tank_full, draw        : raw inputs, asynchronous to the controller clock
//   heater_on, valve_open  : actuator enables
//   state_o                : encoded controller state
//   led                    : one-hot state bar plus tick blinker
//   digit4..digit1         : active-low 7-segment patterns, digit4 leftmost
// master = environment (drives sensors); slave = controller.
interface dispenser_ctrl_gen2_if;
    logic       tank_full;
    logic       draw;
    logic       heater_on;
    logic       valve_open;
    logic [2:0] state_o;
    logic [7:0] led;
    logic [6:0] digit4;
    logic [6:0] digit3;
    logic [6:0] digit2;
    logic [6:0] digit1;

    modport master (
        output tank_full, draw,
        input  heater_on, valve_open, state_o, led, digit4, digit3, digit2, digit1
    );

    modport slave (
        input  tank_full, draw,
        output heater_on, valve_open, state_o, led, digit4, digit3, digit2, digit1
    );
endinterface

// File: rtl/dispenser_ctrl_gen2.sv
// Hot-water dispenser controller.
// Synchronises the tank-level and draw inputs through two flops each, runs a
// six-state FSM (EMPTY, HEATING, HOT, DRAWING, REHEAT, FAULT), times the
// heat/reheat/draw phases from a shared prescaled tick and drives the heater,
// the valve, a state LED bar and four 7-segment digits. Every output is a
// register loaded from the current state, so outputs trail the state by one
// clock.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (also closes the valve at once)
//   bus  : slave side of dispenser_ctrl_gen2_if (sensors in, actuators and
//          display out)
module dispenser_ctrl_gen2 #(
    parameter int CLK_PER_TICK  = 50,
    parameter int HEAT_SECS     = 10,
    parameter int REHEAT_SECS   = 5,
    parameter int MAX_DRAW_SECS = 8,
    parameter int TW            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dispenser_ctrl_gen2_if.slave bus
);

    localparam int              PW         = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_TICK - 1);
    localparam int              SW         = (TW < 16) ? TW : 16;
    localparam logic [6:0]      SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]      SEG_DASH   = 7'b1111110;
    localparam logic [6:0]      SEG_F      = 7'b0111000;

    typedef enum logic [2:0] {
        S_EMPTY   = 3'd0,
        S_HEATING = 3'd1,
        S_HOT     = 3'd2,
        S_DRAWING = 3'd3,
        S_REHEAT  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------
    // Input synchronisers: bit 0 = tank_full, bit 1 = draw
    // ---------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] sync_in;
    logic       full_s;
    logic       draw_s;

    assign async_in = {bus.draw, bus.tank_full};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic s1_q;
        logic s2_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= async_in[gi];
                s2_q <= s1_q;
            end
        end
        assign sync_in[gi] = s2_q;
    end

    assign full_s = sync_in[0];
    assign draw_s = sync_in[1];

    // ---------------------------------------------------------------
    // State, timer and cup counter
    // ---------------------------------------------------------------
    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [TW-1:0]  remaining_q, remaining_d;
    logic [TW-1:0]  cups_q, cups_d;
    logic           tog_q, tog_d;
    logic           timed;
    logic           tick;
    logic           expiry;
    logic           cup_inc;

    assign timed  = (state_q == S_HEATING) || (state_q == S_DRAWING) || (state_q == S_REHEAT);
    assign tick   = timed && (presc_q == PRESC_LAST);
    // Expiry is the tick that would take remaining from 1 to 0.
    assign expiry = tick && (remaining_q == TW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; tank empty beats draw, draw beats expiry.
    always_comb begin
        state_d = state_q;
        cup_inc = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (full_s) state_d = S_HEATING;
            end
            S_HEATING: begin
                if (!full_s)     state_d = S_EMPTY;
                else if (expiry) state_d = S_HOT;
            end
            S_HOT: begin
                if (!full_s)     state_d = S_EMPTY;
                else if (draw_s) state_d = S_DRAWING;
            end
            S_DRAWING: begin
                if (!full_s) begin
                    state_d = S_EMPTY;
                end else if (!draw_s) begin
                    state_d = S_REHEAT;
                    cup_inc = 1'b1;
                end else if (expiry) begin
                    state_d = S_FAULT;
                end
            end
            S_REHEAT: begin
                if (!full_s)     state_d = S_EMPTY;
                else if (draw_s) state_d = S_DRAWING;
                else if (expiry) state_d = S_HOT;
            end
            S_FAULT: begin
                if (!full_s && !draw_s) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Timer: any state change reloads (or zeroes) the timer, so a REHEAT ->
    // DRAWING redraw gets a fresh draw budget.
    always_comb begin
        presc_d     = '0;
        remaining_d = '0;
        if (state_d != state_q) begin
            case (state_d)
                S_HEATING: remaining_d = TW'(HEAT_SECS);
                S_REHEAT:  remaining_d = TW'(REHEAT_SECS);
                S_DRAWING: remaining_d = TW'(MAX_DRAW_SECS);
                default:   remaining_d = '0;
            endcase
        end else if (timed) begin
            if (tick) begin
                remaining_d = remaining_q - TW'(1);
            end else begin
                presc_d     = presc_q + PW'(1);
                remaining_d = remaining_q;
            end
        end
    end

    assign tog_d  = tog_q ^ tick;
    assign cups_d = (cup_inc && (cups_q != {TW{1'b1}})) ? cups_q + TW'(1) : cups_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            remaining_q <= '0;
            cups_q      <= '0;
            tog_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            cups_q      <= cups_d;
            tog_q       <= tog_d;
        end
    end

    // ---------------------------------------------------------------
    // Output logic (registered)
    // ---------------------------------------------------------------
    logic        heater_d, heater_q;
    logic        valve_d, valve_q;
    logic [2:0]  state_o_d, state_o_q;
    logic [7:0]  led_d, led_q;
    logic [TW-1:0] shown_src;
    logic [15:0] shown;
    logic [27:0] digits_q;

    always_comb begin
        heater_d  = (state_q == S_HEATING) || (state_q == S_REHEAT);
        valve_d   = (state_q == S_DRAWING);
        state_o_d = state_q;
        led_d     = 8'h00;
        case (state_q)
            S_EMPTY:   led_d[0] = 1'b1;
            S_HEATING: led_d[1] = 1'b1;
            S_HOT:     led_d[2] = 1'b1;
            S_DRAWING: led_d[3] = 1'b1;
            S_REHEAT:  led_d[4] = 1'b1;
            S_FAULT:   led_d[7] = 1'b1;
            default:   led_d    = 8'h00;
        endcase
        led_d[6] = tog_q;
    end

    // HOT shows the cup count; the timed states show remaining seconds.
    assign shown_src = (state_q == S_HOT) ? cups_q : remaining_q;
    assign shown     = 16'(shown_src[SW-1:0]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [6:0] seg_d;
        logic [6:0] seg_q;
        always_comb begin
            case (state_q)
                S_EMPTY: seg_d = SEG_DASH;
                S_FAULT: seg_d = (gi == 3) ? SEG_F : SEG_BLANK;
                default: seg_d = hex7(shown[gi*4 +: 4]);
            endcase
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                seg_q <= SEG_BLANK;
            end else begin
                seg_q <= seg_d;
            end
        end
        assign digits_q[gi*7 +: 7] = seg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heater_q  <= 1'b0;
            valve_q   <= 1'b0;
            state_o_q <= 3'd0;
            led_q     <= 8'h00;
        end else begin
            heater_q  <= heater_d;
            valve_q   <= valve_d;
            state_o_q <= state_o_d;
            led_q     <= led_d;
        end
    end

    assign bus.heater_on  = heater_q;
    assign bus.valve_open = valve_q;
    assign bus.state_o    = state_o_q;
    assign bus.led        = led_q;
    assign bus.digit1     = digits_q[6:0];
    assign bus.digit2     = digits_q[13:7];
    assign bus.digit3     = digits_q[20:14];
    assign bus.digit4     = digits_q[27:21];

endmodule

// File: tb/tb_dispenser_ctrl_gen2.sv
module tb_dispenser_ctrl_gen2;

    localparam int CPT    = 4;
    localparam int HEAT   = 3;
    localparam int REHEAT = 2;
    localparam int MAXD   = 5;

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b1111110;
    localparam logic [6:0]  SEG_F     = 7'b0111000;
    localparam logic [40:0] RESET_VEC = {1'b0, 1'b0, 3'd0, 8'h00, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};

    logic clk = 1'b0;
    logic rst = 1'b1;

    dispenser_ctrl_gen2_if bus();

    dispenser_ctrl_gen2 #(
        .CLK_PER_TICK (CPT),
        .HEAT_SECS    (HEAT),
        .REHEAT_SECS  (REHEAT),
        .MAX_DRAW_SECS(MAXD),
        .TW           (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] seg_tab [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [40:0] obs;
    assign obs = {bus.heater_on, bus.valve_open, bus.state_o, bus.led,
                  bus.digit4, bus.digit3, bus.digit2, bus.digit1};

    // ---------------------------------------------------------------
    // Reference model: state names as integers, time in a timed state kept
    // as cycles elapsed since entry; remaining seconds derived by division.
    // ---------------------------------------------------------------
    int          m_state = 0;
    int          m_e     = 0;
    int          m_cups  = 0;
    bit          m_tog   = 1'b0;
    bit          hf0 = 0, hf1 = 0, hd0 = 0, hd1 = 0;
    logic [40:0] exp_out = RESET_VEC;
    bit          mf, md, mtimed, mtick, mexp;
    int          mnext;

    function automatic int secs_of(input int st);
        case (st)
            1:       return HEAT;
            3:       return MAXD;
            4:       return REHEAT;
            default: return 0;
        endcase
    endfunction

    function automatic logic [40:0] expect_vec(input int st, input int e, input int cups, input bit tog);
        logic [7:0]  l;
        logic [27:0] d;
        int          shown;
        l = 8'h00;
        case (st)
            0: l[0] = 1'b1;
            1: l[1] = 1'b1;
            2: l[2] = 1'b1;
            3: l[3] = 1'b1;
            4: l[4] = 1'b1;
            default: l[7] = 1'b1;
        endcase
        l[6] = tog;
        if (st == 0) begin
            d = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
        end else if (st == 5) begin
            d = {SEG_F, SEG_BLANK, SEG_BLANK, SEG_BLANK};
        end else begin
            shown = (st == 2) ? cups : secs_of(st) - e / CPT;
            d = {seg_tab[(shown >> 12) & 15], seg_tab[(shown >> 8) & 15],
                 seg_tab[(shown >> 4) & 15], seg_tab[shown & 15]};
        end
        return {(st == 1 || st == 4), (st == 3), 3'(st), l, d};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_e = 0; m_cups = 0; m_tog = 1'b0;
            hf0 = 0; hf1 = 0; hd0 = 0; hd1 = 0;
            exp_out = RESET_VEC;
        end else begin
            exp_out = expect_vec(m_state, m_e, m_cups, m_tog);
            mf = hf1; md = hd1;
            hf1 = hf0; hd1 = hd0;
            hf0 = bus.tank_full; hd0 = bus.draw;
            mtimed = (m_state == 1) || (m_state == 3) || (m_state == 4);
            mtick  = mtimed && (m_e % CPT == CPT - 1);
            mexp   = mtimed && (m_e == secs_of(m_state) * CPT - 1);
            if (mtick) m_tog = !m_tog;
            mnext = m_state;
            case (m_state)
                0: if (mf) mnext = 1;
                1: if (!mf) mnext = 0; else if (mexp) mnext = 2;
                2: if (!mf) mnext = 0; else if (md) mnext = 3;
                3: begin
                    if (!mf) mnext = 0;
                    else if (!md) begin
                        mnext = 4;
                        if (m_cups < 65535) m_cups++;
                    end else if (mexp) mnext = 5;
                end
                4: if (!mf) mnext = 0; else if (md) mnext = 3; else if (mexp) mnext = 2;
                default: if (!mf && !md) mnext = 0;
            endcase
            m_e = (mnext != m_state) ? 0 : m_e + 1;
            m_state = mnext;
        end
    end

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        bus.tank_full = 1'b0;
        bus.draw = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_hold: outputs %h, expected %h", obs, RESET_VEC);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL reset_release: outputs %h, expected %h", obs, exp_out);
            end
        end
        vectors++;
        if (bus.led !== 8'h01 || bus.state_o !== 3'd0 || bus.heater_on !== 1'b0 || bus.valve_open !== 1'b0 ||
            {bus.digit4, bus.digit3, bus.digit2, bus.digit1} !== {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH}) begin
            miscompares++;
            $display("FAIL empty_idle: outputs %h, expected led=01 state=0 digits dashed", obs);
        end
        $display("test_reset: done");
    endtask

    task automatic test_heat();
        int heat_cycles = 0;
        int three_cycles = 0;
        bit heater_ok = 1'b1;
        bus.tank_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL heat: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.state_o == 3'd1) begin
                heat_cycles++;
                if (bus.heater_on !== 1'b1) heater_ok = 1'b0;
                if (bus.digit1 === seg_tab[3]) three_cycles++;
            end
        end
        vectors++;
        if (heat_cycles != HEAT * CPT) begin
            miscompares++;
            $display("FAIL heat_len: %0d cycles in HEATING, expected %0d", heat_cycles, HEAT * CPT);
        end
        vectors++;
        if (!heater_ok || three_cycles != CPT) begin
            miscompares++;
            $display("FAIL heat_out: heater_ok=%0d digit3_cycles=%0d, expected 1 and %0d", heater_ok, three_cycles, CPT);
        end
        vectors++;
        if (bus.state_o !== 3'd2 || bus.heater_on !== 1'b0 ||
            {bus.digit4, bus.digit3, bus.digit2, bus.digit1} !== {4{seg_tab[0]}}) begin
            miscompares++;
            $display("FAIL heat_hot: outputs %h, expected HOT heater off digits 0000", obs);
        end
        $display("test_heat: done");
    endtask

    task automatic test_draw();
        int valve_cycles = 0;
        int reheat_cycles = 0;
        logic [2:0] prev = 3'd2;
        bus.draw = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL draw: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.valve_open === 1'b1) valve_cycles++;
            if (bus.state_o == 3'd4) begin
                reheat_cycles++;
                if (prev != 3'd4) begin
                    vectors++;
                    if (bus.digit1 !== seg_tab[2] || bus.digit2 !== seg_tab[0]) begin
                        miscompares++;
                        $display("FAIL reheat_digits: digit1 %b, expected %b", bus.digit1, seg_tab[2]);
                    end
                end
            end
            prev = bus.state_o;
            if (i == 5) bus.draw = 1'b0;
        end
        vectors++;
        if (valve_cycles != 6 || reheat_cycles != REHEAT * CPT) begin
            miscompares++;
            $display("FAIL draw_len: valve %0d reheat %0d, expected 6 and %0d", valve_cycles, reheat_cycles, REHEAT * CPT);
        end
        vectors++;
        if (bus.state_o !== 3'd2 || bus.digit1 !== seg_tab[1]) begin
            miscompares++;
            $display("FAIL draw_cups: state %0d digit1 %b, expected 2 and %b", bus.state_o, bus.digit1, seg_tab[1]);
        end
        $display("test_draw: done");
    endtask

    task automatic test_fault();
        int valve_cycles = 0;
        int fault_cycles = 0;
        int fault_bad = 0;
        bus.draw = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL fault: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.valve_open === 1'b1) valve_cycles++;
            if (bus.state_o == 3'd5) begin
                fault_cycles++;
                if (bus.valve_open !== 1'b0 || bus.led[7] !== 1'b1 || bus.digit4 !== SEG_F) fault_bad++;
            end
            if (i == 24) begin
                bus.draw = 1'b0;
                bus.tank_full = 1'b0;
            end
        end
        vectors++;
        if (valve_cycles != MAXD * CPT) begin
            miscompares++;
            $display("FAIL fault_len: valve open %0d cycles, expected %0d", valve_cycles, MAXD * CPT);
        end
        vectors++;
        if (fault_cycles == 0 || fault_bad != 0) begin
            miscompares++;
            $display("FAIL fault_out: fault cycles %0d bad %0d, expected >0 and 0", fault_cycles, fault_bad);
        end
        vectors++;
        if (bus.state_o !== 3'd0) begin
            miscompares++;
            $display("FAIL fault_exit: state %0d, expected 0", bus.state_o);
        end
        $display("test_fault: done");
    endtask

    task automatic test_empty_mid_draw();
        bus.tank_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL mid_draw_heat: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.state_o == 3'd2) break;
        end
        bus.draw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL mid_draw: outputs %h, expected %h", obs, exp_out);
            end
            if (i == 4) bus.tank_full = 1'b0;
        end
        vectors++;
        if (bus.state_o !== 3'd0 || bus.valve_open !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_draw_empty: state %0d valve %0d, expected 0 and 0", bus.state_o, bus.valve_open);
        end
        bus.draw = 1'b0;
        bus.tank_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL mid_draw_reheat: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.state_o == 3'd2) break;
        end
        vectors++;
        if (bus.state_o !== 3'd2 || bus.digit1 !== seg_tab[1]) begin
            miscompares++;
            $display("FAIL mid_draw_cups: state %0d digit1 %b, expected 2 and %b", bus.state_o, bus.digit1, seg_tab[1]);
        end
        $display("test_empty_mid_draw: done");
    endtask

    task automatic test_reheat_redraw();
        bit armed = 1'b0;
        bit seen = 1'b0;
        logic [2:0] prev = 3'd2;
        bus.draw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL redraw_setup: outputs %h, expected %h", obs, exp_out);
            end
            if (i == 2) bus.draw = 1'b0;
            if (i > 2 && m_state == 4 && m_e == REHEAT * CPT - 3) begin
                bus.draw = 1'b1;
                armed = 1'b1;
                break;
            end
        end
        vectors++;
        if (!armed) begin
            miscompares++;
            $display("FAIL redraw_timeout: REHEAT not reached, expected within 40 cycles");
        end
        prev = bus.state_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL redraw: outputs %h, expected %h", obs, exp_out);
            end
            if (prev == 3'd4 && bus.state_o != 3'd4) begin
                seen = 1'b1;
                vectors++;
                if (bus.state_o !== 3'd3 || bus.digit1 !== seg_tab[5] || bus.digit2 !== seg_tab[0]) begin
                    miscompares++;
                    $display("FAIL redraw_state: state %0d digit1 %b, expected 3 and %b", bus.state_o, bus.digit1, seg_tab[5]);
                end
            end
            prev = bus.state_o;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL redraw_seen: no exit from REHEAT, expected DRAWING");
        end
        bus.draw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL redraw_tail: outputs %h, expected %h", obs, exp_out);
            end
            if (bus.state_o == 3'd2) break;
        end
        vectors++;
        if (bus.state_o !== 3'd2 || bus.digit1 !== seg_tab[3]) begin
            miscompares++;
            $display("FAIL redraw_cups: state %0d digit1 %b, expected 2 and %b", bus.state_o, bus.digit1, seg_tab[3]);
        end
        $display("test_reheat_redraw: done");
    endtask

    task automatic test_rst_mid_heat();
        bus.tank_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL rst_setup: outputs %h, expected %h", obs, exp_out);
            end
            if (i == 5) bus.tank_full = 1'b1;
        end
        vectors++;
        if (bus.state_o !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_heating: state %0d, expected 1", bus.state_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL rst_async: outputs %h, expected %h", obs, RESET_VEC);
        end
        @(negedge clk);
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL rst_held: outputs %h, expected %h", obs, RESET_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.led !== 8'h01 || bus.state_o !== 3'd0 || bus.digit1 !== SEG_DASH) begin
            miscompares++;
            $display("FAIL rst_release: outputs %h, expected EMPTY display", obs);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL rst_after: outputs %h, expected %h", obs, exp_out);
            end
        end
        $display("test_rst_mid_heat: done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out) begin
                miscompares++;
                $display("FAIL random[%0d]: outputs %h, expected %h", i, obs, exp_out);
            end
            if ($urandom_range(0, 39) == 0) bus.tank_full = ~bus.tank_full;
            if ($urandom_range(0, 5) == 0)  bus.draw = ~bus.draw;
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        $display("test_random: done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tank_full = 1'b0;
        bus.draw = 1'b0;
        test_reset();
        test_heat();
        test_draw();
        test_fault();
        test_empty_mid_draw();
        test_reheat_redraw();
        test_rst_mid_heat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
